beam_steer_tx: RTL and testbench



---
 rtl/beam_pkg.sv | 21 ++
 rtl/steer_delay_line.sv | 52 +++++
 rtl/beam_steer_tx.sv | 130 +++++++++++++
 tb/tb_beam_steer_tx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/beam_pkg.sv
// Shared steering scale for the beam-forming transmit and receive paths.
// Both ends import this so a steering index means the same direction everywhere.
package beam_pkg;

   localparam int MAX_DELAY    = 30;
   localparam int BUF_DEPTH    = 64;
   localparam int CENTER_INDEX = MAX_DELAY;
   localparam int INDEX_MAX    = 2 * MAX_DELAY;
   localparam int IDX_W        = 6;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_RUN  = 1'b1
   } tx_state_e;

   function automatic logic index_legal(input logic [IDX_W-1:0] idx,
                                        input logic [IDX_W-1:0] max_idx);
      return (idx <= max_idx);
   endfunction

endpackage

// File: rtl/steer_delay_line.sv
// Circular sample history with one write port and two delay-addressed taps.
// A tap of delay 0 bypasses the buffer and returns the sample being written.
module steer_delay_line import beam_pkg::*; #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 64,
   parameter int DLY_W      = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_wr_en,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [DLY_W-1:0]      i_dly_a,
   input  logic [DLY_W-1:0]      i_dly_b,
   output logic [DATA_WIDTH-1:0] o_rd_a,
   output logic [DATA_WIDTH-1:0] o_rd_b
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]      r_wr_ptr;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DLY_W-1:0]      w_dly [2];
   logic [DATA_WIDTH-1:0] w_rd  [2];

   assign w_dly[0] = i_dly_a;
   assign w_dly[1] = i_dly_b;
   assign o_rd_a   = w_rd[0];
   assign o_rd_b   = w_rd[1];

   // Clearing on reset makes taps that reach before the first write read as silence.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_wr_en) begin
         r_mem[r_wr_ptr] <= i_wr_data;
         r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_tap
         logic [PTR_W-1:0] w_addr;
         assign w_addr    = r_wr_ptr - PTR_W'(w_dly[gi]);
         assign w_rd[gi]  = (w_dly[gi] == '0) ? i_wr_data : r_mem[w_addr];
      end
   endgenerate

endmodule

// File: rtl/beam_steer_tx.sv
// Two-channel transmit beam steering: left delayed by the active index, right by
// the fixed centre delay. Index changes take effect only on a sample boundary.
module beam_steer_tx import beam_pkg::*; #(
   parameter int DATA_WIDTH = 16,
   parameter int MAX_DELAY  = beam_pkg::MAX_DELAY,
   parameter int BUF_DEPTH  = beam_pkg::BUF_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] sample_in,
   input  logic                  sample_valid,
   input  logic [IDX_W-1:0]      steer_index,
   input  logic                  steer_load,
   output logic [DATA_WIDTH-1:0] left_out,
   output logic [DATA_WIDTH-1:0] right_out,
   output logic                  out_valid,
   output logic                  primed,
   output logic                  steer_err,
   output logic [IDX_W-1:0]      active_index
);

   localparam int               IDX_LIMIT = 2 * MAX_DELAY;
   localparam logic [IDX_W-1:0] CENTER    = IDX_W'(MAX_DELAY);
   localparam logic [IDX_W-1:0] LIMIT     = IDX_W'(IDX_LIMIT);
   localparam int               FILL_W    = $clog2(IDX_LIMIT + 1);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(IDX_LIMIT - 1);

   tx_state_e             r_state;
   logic [FILL_W-1:0]     r_fill_count;
   logic                  r_primed;
   logic [IDX_W-1:0]      r_active_index;
   logic [IDX_W-1:0]      r_pending_index;
   logic                  r_pending;
   logic                  r_steer_err;
   logic [DATA_WIDTH-1:0] r_left;
   logic [DATA_WIDTH-1:0] r_right;
   logic                  r_out_valid;

   logic                  w_steer_ok;
   logic [IDX_W-1:0]      w_dly_left;
   logic [DATA_WIDTH-1:0] w_tap_left;
   logic [DATA_WIDTH-1:0] w_tap_right;

   assign w_steer_ok = index_legal(steer_index, LIMIT);
   // A pending index loaded in an earlier cycle already governs this sample.
   assign w_dly_left = r_pending ? r_pending_index : r_active_index;

   steer_delay_line #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (BUF_DEPTH),
      .DLY_W      (IDX_W)
   ) u_delay_line (
      .clk        (clk),
      .reset      (reset),
      .i_wr_en    (sample_valid),
      .i_wr_data  (sample_in),
      .i_dly_a    (w_dly_left),
      .i_dly_b    (CENTER),
      .o_rd_a     (w_tap_left),
      .o_rd_b     (w_tap_right)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_FILL;
         r_fill_count <= '0;
         r_primed     <= 1'b0;
      end else begin
         case (r_state)
            ST_FILL: begin
               if (sample_valid) begin
                  r_fill_count <= r_fill_count + 1'b1;
                  if (r_fill_count == FILL_LAST) begin
                     r_state  <= ST_RUN;
                     r_primed <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               r_primed <= 1'b1;
            end
            default: begin
               r_state <= ST_FILL;
            end
         endcase
      end
   end

   // Load after transfer so a load coinciding with a sample stays pending.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_active_index  <= CENTER;
         r_pending_index <= CENTER;
         r_pending       <= 1'b0;
         r_steer_err     <= 1'b0;
      end else begin
         r_steer_err <= steer_load && !w_steer_ok;
         if (sample_valid && r_pending) begin
            r_active_index <= r_pending_index;
            r_pending      <= 1'b0;
         end
         if (steer_load && w_steer_ok) begin
            r_pending_index <= steer_index;
            r_pending       <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_left      <= '0;
         r_right     <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= sample_valid;
         if (sample_valid) begin
            r_left  <= w_tap_left;
            r_right <= w_tap_right;
         end
      end
   end

   assign left_out     = r_left;
   assign right_out    = r_right;
   assign out_valid    = r_out_valid;
   assign primed       = r_primed;
   assign steer_err    = r_steer_err;
   assign active_index = r_active_index;

endmodule

// File: tb/tb_beam_steer_tx.sv
// Directed bench for beam_steer_tx: stimulus pushes expected outputs into a
// queue, a negedge monitor pops and compares on every out_valid.
module tb_beam_steer_tx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] sample_in = '0;
   logic        sample_valid = 1'b0;
   logic [5:0]  steer_index = '0;
   logic        steer_load = 1'b0;
   logic [15:0] left_out;
   logic [15:0] right_out;
   logic        out_valid;
   logic        primed;
   logic        steer_err;
   logic [5:0]  active_index;

   beam_steer_tx dut (
      .clk          (clk),
      .reset        (reset),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .steer_index  (steer_index),
      .steer_load   (steer_load),
      .left_out     (left_out),
      .right_out    (right_out),
      .out_valid    (out_valid),
      .primed       (primed),
      .steer_err    (steer_err),
      .active_index (active_index)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [15:0] l;
      logic [15:0] r;
      logic        p;
      logic [5:0]  a;
      int          c;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d cyc=%0d", name, act, exp, cyc);
      end
   endtask

   // Monitor: every out_valid must match the oldest outstanding expectation.
   exp_t m_e;
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out_valid actual=1 required=0 cyc=%0d", cyc);
         end else begin
            m_e = sb.pop_front();
            chk("left_out",     32'(left_out),     32'(m_e.l));
            chk("right_out",    32'(right_out),    32'(m_e.r));
            chk("primed",       32'(primed),       32'(m_e.p));
            chk("active_index", 32'(active_index), 32'(m_e.a));
            chk("latency_cyc",  32'(cyc),          32'(m_e.c));
         end
      end
   end

   // Called at posedge+1; returns at the next posedge+1 with strobes dropped.
   task automatic send(input int v, input int el, input int er, input logic ep,
                       input int ea, input logic ld, input int idx);
      exp_t e;
      sample_in    = v[15:0];
      sample_valid = 1'b1;
      steer_load   = ld;
      steer_index  = idx[5:0];
      e.l = el[15:0];
      e.r = er[15:0];
      e.p = ep;
      e.a = ea[5:0];
      e.c = cyc + 1;
      sb.push_back(e);
      @(posedge clk); #1;
      sample_valid = 1'b0;
      steer_load   = 1'b0;
   endtask

   task automatic load(input int idx);
      steer_load  = 1'b1;
      steer_index = idx[5:0];
      @(posedge clk); #1;
      steer_load  = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk); #1;
   endtask

   function automatic int dly(input int n, input int d);
      return (n >= d) ? (n - d + 1) : 0;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_left_out",     32'(left_out),     32'd0);
      chk("rst_right_out",    32'(right_out),    32'd0);
      chk("rst_out_valid",    32'(out_valid),    32'd0);
      chk("rst_primed",       32'(primed),       32'd0);
      chk("rst_steer_err",    32'(steer_err),    32'd0);
      chk("rst_active_index", 32'(active_index), 32'd30);
      reset = 1'b0;

      // Broadside ramp, back-to-back, crossing the 63->0 pointer wrap.
      for (int n = 0; n < 70; n++)
         send(n + 1, dly(n, 30), dly(n, 30), n >= 59, 30, 1'b0, 0);
      idle();

      // Illegal index rejected, active index untouched.
      load(61);
      @(negedge clk);
      chk("err_pulse",     32'(steer_err),    32'd1);
      chk("err_active",    32'(active_index), 32'd30);
      @(posedge clk); #1;
      @(negedge clk);
      chk("err_one_cycle", 32'(steer_err),    32'd0);
      @(posedge clk); #1;

      // Load 45 with a sample: that sample still uses 30, the next uses 45.
      send(71, 41, 41, 1'b1, 30, 1'b1, 45);
      send(72, 27, 42, 1'b1, 45, 1'b0, 0);

      // Index 0: left is the current sample, with idle gaps between samples.
      load(0);
      @(negedge clk);
      chk("legal_no_err", 32'(steer_err), 32'd0);
      @(posedge clk); #1;
      for (int n = 72; n < 82; n++) begin
         send(n + 1, n + 1, n - 29, 1'b1, 0, 1'b0, 0);
         idle();
      end

      // Several loads before a sample: the last legal one (60) wins.
      load(10);
      load(60);
      load(62);
      @(negedge clk);
      chk("err_after_loads", 32'(steer_err),    32'd1);
      chk("active_waits",    32'(active_index), 32'd0);
      @(posedge clk); #1;

      // 100 back-to-back samples at index 60, spanning another pointer wrap.
      for (int n = 82; n < 182; n++)
         send(n + 1, n - 59, n - 29, 1'b1, 60, 1'b0, 0);

      // Reset with an output in flight.
      for (int n = 182; n < 186; n++)
         send(n + 1, n - 59, n - 29, 1'b1, 60, 1'b0, 0);
      sample_in    = 16'd187;
      sample_valid = 1'b1;
      @(posedge clk); #1;
      reset        = 1'b1;
      sample_valid = 1'b0;
      #1;
      chk("mid_rst_out_valid",    32'(out_valid),    32'd0);
      chk("mid_rst_left_out",     32'(left_out),     32'd0);
      chk("mid_rst_right_out",    32'(right_out),    32'd0);
      chk("mid_rst_primed",       32'(primed),       32'd0);
      chk("mid_rst_active_index", 32'(active_index), 32'd30);
      idle();
      idle();
      reset = 1'b0;

      // After reset the buffer history is gone: early taps read zero.
      for (int n = 0; n < 35; n++)
         send(n + 1, dly(n, 30), dly(n, 30), 1'b0, 30, 1'b0, 0);

      repeat (4) idle();
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
